pixel_writer: RTL and testbench

Streams 8-bit pixels from a producer, such as a fractal engine or a test pattern source, into the SDRAM frame buffer in MEM_CLK domain. It is the write-side counterpart of `frame_reader`:
- Packs four pixels per 32-bit word.
- Buffers words in a small FIFO.
- Requests the SDRAM mux and issues bursts of word writes to the controller's command interface.
- Advances the frame address with wrap-around.

---
 rtl/pixel_writer.sv | 151 +++++++++++++++
 tb/tb_pixel_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// pixel_writer: packs 8-bit pixels four to a 32-bit word, buffers the words in
// a small FIFO and writes them into the SDRAM frame buffer in bursts, one
// mux grant per burst, wrapping the word address at the end of the frame.
module pixel_writer #(
  parameter logic [21:0] BASE_ADDR   = 22'd0,
  parameter int          FRAME_WORDS = 96000,
  parameter int          BURST_WORDS = 8,
  parameter int          FIFO_WORDS  = 16,
  parameter logic [1:0]  CMD_NOP     = 2'b00,
  parameter logic [1:0]  CMD_WRITE   = 2'b01
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [7:0]  i_Pixel,
  input  logic        i_Pixel_Valid,
  output logic        o_Pixel_Ready,
  input  logic        i_Frame_Start,
  input  logic        i_SDRAM_Grant,
  input  logic        i_Data_Write_Done,
  output logic        o_SDRAM_Request,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  output logic [31:0] o_Data_Write,
  output logic        o_Frame_Done
);

  localparam int PW = $clog2(FIFO_WORDS);
  localparam int CW = $clog2(FIFO_WORDS + 1);
  localparam int BW = $clog2(BURST_WORDS + 1);
  localparam logic [21:0] LAST_ADDR = BASE_ADDR + 22'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, GAP} state_t;

  state_t          state, state_nxt;
  logic [3:0][7:0] lane_q;
  logic [3:0][7:0] push_word;
  logic [1:0]      lane;
  logic [31:0]     fifo_mem [FIFO_WORDS];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [21:0]     addr;
  logic [BW-1:0]   burst_cnt;
  logic            start_pending;
  logic            last_word;

  logic accept, push, pop, fifo_empty, fifo_full, burst_ready, burst_done;
  logic apply_start;

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CW'(FIFO_WORDS));
  assign burst_ready   = (count >= CW'(BURST_WORDS));
  assign burst_done    = (burst_cnt == BW'(BURST_WORDS));
  assign o_Pixel_Ready = !fifo_full && !start_pending;
  assign accept        = i_Pixel_Valid && o_Pixel_Ready;
  assign push          = accept && (lane == 2'd3);
  assign pop           = (state == WRITE) && i_Data_Write_Done;
  assign apply_start   = (state == IDLE) && start_pending && fifo_empty;

  // Word being pushed: three stored lanes plus the incoming pixel in lane 3.
  always_comb begin
    push_word    = lane_q;
    push_word[3] = i_Pixel;
  end

  // Pixel lane storage and FIFO memory carry no reset; lane/pointers qualify them.
  always_ff @(posedge i_Clk) begin
    if (accept && lane != 2'd3) lane_q[lane] <= i_Pixel;
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  // State register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. A pending frame start with a partly filled FIFO forces a
  // short flush burst so the buffered words drain before the restart; a burst
  // also ends early if the FIFO runs dry (only possible during such a flush).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (burst_ready || (start_pending && !fifo_empty)) state_nxt = REQ;
      REQ:   if (i_SDRAM_Grant) state_nxt = WRITE;
      WRITE: if (i_Data_Write_Done) state_nxt = GAP;
             else if (!i_SDRAM_Grant) state_nxt = REQ;
      GAP:   state_nxt = (burst_done || fifo_empty) ? IDLE : WRITE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs, all decoded from registered state.
  always_comb begin
    o_SDRAM_Request = 1'b0;
    o_Command       = CMD_NOP;
    o_Data_Address  = '0;
    o_Data_Write    = '0;
    o_Frame_Done    = 1'b0;
    case (state)
      REQ:   o_SDRAM_Request = 1'b1;
      WRITE: begin
        o_SDRAM_Request = 1'b1;
        o_Command       = CMD_WRITE;
        o_Data_Address  = addr;
        o_Data_Write    = fifo_mem[rd_ptr];
      end
      GAP: begin
        o_SDRAM_Request = 1'b1;
        o_Frame_Done    = last_word;
      end
      default: ;
    endcase
  end

  // Datapath: lane counter, FIFO pointers/count, address, burst count, frame start.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      lane          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      addr          <= BASE_ADDR;
      burst_cnt     <= '0;
      start_pending <= 1'b0;
      last_word     <= 1'b0;
    end else begin
      if (accept) lane <= lane + 2'd1;
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (state == REQ && i_SDRAM_Grant) burst_cnt <= '0;
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        addr      <= (addr == LAST_ADDR) ? BASE_ADDR : addr + 22'd1;
        burst_cnt <= burst_cnt + BW'(1);
        last_word <= (addr == LAST_ADDR);
      end
      if (apply_start) begin
        addr          <= BASE_ADDR;
        lane          <= '0;
        start_pending <= 1'b0;
      end
      // A new pulse wins over a same-cycle apply so it is never lost.
      if (i_Frame_Start) start_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus pushes expected writes, a forked
// monitor acts as the SDRAM controller and checks every completed write.
module tb_pixel_writer;
  localparam logic [21:0] BASE  = 22'h100;
  localparam int          FW    = 16;
  localparam logic [21:0] LAST  = 22'h10F;
  localparam logic [1:0]  C_NOP = 2'b00;
  localparam logic [1:0]  C_WR  = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n, valid, ready, fstart, grant, done, req, fdone;
  logic [7:0]  pix;
  logic [1:0]  cmd;
  logic [21:0] waddr;
  logic [31:0] wdata;

  typedef struct packed { logic [21:0] addr; logic [31:0] data; } wr_t;
  wr_t         sb[$];
  int          n_tests = 0, n_fail = 0;
  int          lat = 2, fd_count = 0, stalls = 0, lane_m = 0;
  logic [21:0] addr_m;
  logic [31:0] word_m;

  always #5 clk = ~clk;

  pixel_writer #(.BASE_ADDR(BASE), .FRAME_WORDS(FW), .BURST_WORDS(8),
                 .FIFO_WORDS(16), .CMD_NOP(C_NOP), .CMD_WRITE(C_WR)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Pixel(pix), .i_Pixel_Valid(valid),
    .o_Pixel_Ready(ready), .i_Frame_Start(fstart), .i_SDRAM_Grant(grant),
    .i_Data_Write_Done(done), .o_SDRAM_Request(req), .o_Command(cmd),
    .o_Data_Address(waddr), .o_Data_Write(wdata), .o_Frame_Done(fdone));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Controller model + checker: done after 'lat' WRITE cycles, pop and compare.
  task automatic monitor();
    int   wcnt = 0;
    logic exp_fd = 1'b0;
    wr_t  e;
    forever begin
      @(negedge clk);
      if (exp_fd || fdone) chk("frame_done", 32'(fdone), 32'(exp_fd));
      if (fdone) fd_count++;
      exp_fd = 1'b0;
      if (cmd == C_WR) begin
        if (wcnt >= lat - 1) begin
          done = 1'b1;
          wcnt = 0;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_write: got addr %0h data %0h, want none", waddr, wdata);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(waddr), 32'(e.addr));
            chk("wr_data", wdata, e.data);
          end
          exp_fd = (waddr == LAST);
        end else begin
          done = 1'b0;
          wcnt++;
        end
      end else begin
        done = 1'b0;
        wcnt = 0;
      end
    end
  endtask

  // Offer one pixel; on acceptance update the packing/address model.
  task automatic send(input logic [7:0] p, input int budget);
    int w = 0;
    pix   = p;
    valid = 1'b1;
    while (!ready && w < budget) begin step(); w++; end
    if (!ready) begin
      fail_msg("send_timeout");
      valid = 1'b0;
    end else begin
      stalls += w;
      step();
      valid = 1'b0;
      word_m[8*lane_m +: 8] = p;
      if (lane_m == 3) begin
        sb.push_back('{addr: addr_m, data: word_m});
        addr_m = (addr_m == LAST) ? BASE : addr_m + 22'd1;
      end
      lane_m = (lane_m + 1) % 4;
    end
  endtask

  task automatic send_range(input logic [7:0] first, input int n, input int budget);
    logic [7:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      send(p, budget);
      p = p + 8'd1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int w = 0;
    while ((sb.size() != 0 || req) && w < budget) begin step(); w++; end
    if (sb.size() != 0 || req) fail_msg(name);
  endtask

  task automatic wait_write(input string name, input int budget);
    int w = 0;
    while (cmd != C_WR && w < budget) begin step(); w++; end
    if (cmd != C_WR) fail_msg(name);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; pix = '0; fstart = 1'b0; grant = 1'b0; done = 1'b0;
    addr_m = BASE; word_m = '0;
    fork
      monitor();
    join_none
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_req",   32'(req),   0);
    chk("rst_cmd",   32'(cmd),   32'(C_NOP));
    chk("rst_addr",  32'(waddr), 0);
    chk("rst_data",  wdata,      0);
    chk("rst_fdone", 32'(fdone), 0);
    chk("rst_ready", 32'(ready), 1);

    // A: one full-rate burst, grant tied high, done 2 cycles after CMD_WRITE.
    grant = 1'b1; lat = 2; stalls = 0;
    send_range(8'h00, 32, 100);
    chk("A_no_stall", 32'(stalls), 0);
    wait_drain("A_drain", 300);

    // B: no grant; FIFO fills at 16 words, request up, command idle.
    grant = 1'b0; stalls = 0;
    send_range(8'h40, 64, 100);
    chk("B_no_stall", 32'(stalls), 0);
    chk("B_ready_low", 32'(ready), 0);
    repeat (3) step();
    chk("B_ready_still_low", 32'(ready), 0);
    chk("B_req", 32'(req), 1);
    chk("B_cmd_nop", 32'(cmd), 32'(C_NOP));
    grant = 1'b1;
    send_range(8'h80, 32, 300);
    wait_drain("B_drain", 600);
    chk("B_frames_done", 32'(fd_count), 2);

    // C: grant lost mid-WRITE before done -> back to REQ, word reissued.
    grant = 1'b0; lat = 3;
    send_range(8'hA0, 32, 100);
    grant = 1'b1;
    wait_write("C_first_write", 50);
    grant = 1'b0;
    step();
    chk("C_cmd_nop", 32'(cmd), 32'(C_NOP));
    chk("C_req_held", 32'(req), 1);
    repeat (2) step();
    chk("C_no_write_wo_grant", 32'(cmd), 32'(C_NOP));
    grant = 1'b1;
    wait_drain("C_drain", 400);

    // D: frame start with 1 buffered word and 2 partial pixels.
    lat = 2;
    send_range(8'hC0, 6, 100);
    fstart = 1'b1;
    step();
    fstart = 1'b0;
    chk("D_ready_low", 32'(ready), 0);
    addr_m = BASE; lane_m = 0;
    begin
      int w = 0;
      while (!ready && w < 100) begin step(); w++; end
      if (!ready) fail_msg("D_ready_return");
    end
    chk("D_flushed_first", 32'(sb.size()), 0);
    send_range(8'hD0, 32, 100);
    wait_drain("D_drain", 400);

    // E: reset during WRITE, then restart from the frame base.
    grant = 1'b0; lat = 4;
    send_range(8'hE0, 32, 100);
    grant = 1'b1;
    wait_write("E_write", 50);
    rst_n = 1'b0;
    step();
    chk("E_req",   32'(req),   0);
    chk("E_cmd",   32'(cmd),   32'(C_NOP));
    chk("E_ready", 32'(ready), 1);
    chk("E_addr",  32'(waddr), 0);
    rst_n = 1'b1;
    sb.delete();
    addr_m = BASE; lane_m = 0; lat = 1;
    send_range(8'hF0, 32, 100);
    wait_drain("E_drain", 400);

    chk("fd_total", 32'(fd_count), 2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
